// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the UART transmit path
package uart_pkg;
  localparam int DATA_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, FETCH, SEND} tx_state_t;
endpackage

// File: rtl/tx_drain_ctrl.sv
// tx_drain_ctrl: drains the TX FIFO into the transmitter one byte at a time and counts accepted bytes
module tx_drain_ctrl
  import uart_pkg::*;
#(
  parameter int DataWidth  = DATA_WIDTH,
  parameter int CountWidth = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_cts_n,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd_en,
  input  logic [DataWidth-1:0]  i_fifo_rd_data,
  output logic [DataWidth-1:0]  o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  input  logic                  i_count_clr,
  output logic [CountWidth-1:0] o_tx_count,
  output logic                  o_busy
);
  tx_state_t state, state_nxt;
  logic go;
  assign go = i_enable && !i_cts_n && !i_fifo_empty;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == IDLE  ? (go ? FETCH : IDLE) :
                state == FETCH ? SEND :
                state == SEND  ? (i_tx_ready ? (go ? FETCH : IDLE) : SEND) :
                IDLE;
  end
  always_comb begin
    o_fifo_rd_en = i_rst_n && go && (state == IDLE || (state == SEND && i_tx_ready));
    o_tx_valid   = i_rst_n && state == SEND;
    o_busy       = i_rst_n && state != IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)            o_tx_data <= '0;
    else if (state == FETCH) o_tx_data <= i_fifo_rd_data;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_count_clr)     o_tx_count <= '0;
    else if (o_tx_valid && i_tx_ready) o_tx_count <= o_tx_count + CountWidth'(1);
  end
endmodule

// File: doc/tx_drain_ctrl.md
TX_DRAIN_CTRL -- requirements
Module: tx_drain_ctrl

Interface
REQ-001 SHALL have parameter DataWidth, default 8, width of FIFO and transmitter data.
REQ-002 SHALL have parameter CountWidth, default 16, width of sent-byte counter.
REQ-003 SHALL have port i_clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_enable  input  1  drain enable; low stops new fetches.
REQ-006 SHALL have port i_cts_n  input  1  clear-to-send, active-low; high stops new fetches.
REQ-007 SHALL have port i_fifo_empty  input  1  TX FIFO empty flag.
REQ-008 SHALL have port o_fifo_rd_en  output  1  one-cycle FIFO read strobe.
REQ-009 SHALL have port i_fifo_rd_data  input  DataWidth  FIFO read data, valid one cycle after o_fifo_rd_en.
REQ-010 SHALL have port o_tx_data  output  DataWidth  byte offered to transmitter.
REQ-011 SHALL have port o_tx_valid  output  1  o_tx_data valid.
REQ-012 SHALL have port i_tx_ready  input  1  transmitter accepts byte when high with o_tx_valid.
REQ-013 SHALL have port i_count_clr  input  1  synchronous clear of o_tx_count.
REQ-014 SHALL have port o_tx_count  output  CountWidth  bytes accepted by transmitter.
REQ-015 SHALL have port o_busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, SEND.
REQ-017 Define "go" = i_enable && !i_cts_n && !i_fifo_empty.
REQ-018 In IDLE, if go, SHALL assert o_fifo_rd_en combinationally that cycle and move to FETCH; else stay IDLE.
REQ-019 In FETCH, SHALL register i_fifo_rd_data into o_tx_data and move to SEND; o_fifo_rd_en low.
REQ-020 In SEND, o_tx_valid SHALL be 1 and o_tx_data SHALL be held stable until i_tx_ready.
REQ-021 In SEND with i_tx_ready: if go, SHALL assert o_fifo_rd_en that cycle and move to FETCH (back-to-back); else move to IDLE.
REQ-022 o_tx_valid SHALL be 0 in IDLE and FETCH.
REQ-023 Latency: go high in IDLE at cycle N -> o_tx_valid high at cycle N+2.
REQ-024 Sustained throughput with i_tx_ready always high SHALL be one byte per 2 cycles.
REQ-025 o_fifo_rd_en SHALL never assert while i_fifo_empty is high (no underflow read).
REQ-026 o_fifo_rd_en SHALL assert at most once per byte; never in FETCH.
REQ-027 Deasserting i_enable or i_cts_n in FETCH or SEND SHALL NOT abort the byte; it completes, then FSM returns to IDLE.
REQ-028 o_tx_count SHALL increment by 1 on each cycle with o_tx_valid && i_tx_ready; wraps modulo 2^CountWidth.
REQ-029 i_count_clr SHALL set o_tx_count to 0 next cycle; wins over simultaneous increment.
REQ-030 i_tx_ready while not in SEND SHALL be ignored.

Reset
REQ-031 On i_rst_n low at a clock edge: state IDLE, o_tx_data 0, o_tx_count 0.
REQ-032 During reset o_fifo_rd_en, o_tx_valid, o_busy SHALL be 0.
REQ-033 Reset in FETCH or SEND SHALL discard the fetched byte; FIFO pointers are not this block's concern.

Structure
REQ-034 Package uart_pkg SHALL hold the state enum typedef (IDLE, FETCH, SEND) and default DataWidth constant.
REQ-035 No sub-module; FSM, data register and counter SHALL be inline in tx_drain_ctrl.
REQ-036 State register and next-state logic SHALL be separate sequential/combinational processes.

Verification
REQ-037 FIFO holds 0xA5, enable=1, cts_n=0, ready=1 -> rd_en at cycle N, valid with 0xA5 at N+2, count=1, back to IDLE.
REQ-038 FIFO holds 0x11,0x22,0x33, ready=1 -> rd_en every 2 cycles, bytes out in order, count=3, no rd_en after empty.
REQ-039 Byte 0x5A in SEND, ready low 10 cycles -> valid and 0x5A held 10 cycles, no rd_en, count unchanged, then accepted.
REQ-040 cts_n raised during SEND with 2 bytes queued -> current byte completes, IDLE, no rd_en until cts_n low again.
REQ-041 count=0xFFFF plus one accept -> count=0x0000; count_clr with simultaneous accept -> count=0.
REQ-042 Reset asserted in SEND -> next cycle valid=0, busy=0, count=0, state IDLE, no rd_en.
